// File: rtl/lupdate_tx_sched_if.sv
// lupdate_tx_sched_if: rpt/fwd request-grant packet streams and the scheduled
// lupdate ingress output. The scheduler uses the slave modport.
interface lupdate_tx_sched_if;
  logic         in_rpt_req;
  logic         out_rpt_gnt;
  logic [133:0] in_rpt_data;
  logic         in_rpt_data_wr;
  logic         in_rpt_data_valid;
  logic         in_rpt_data_valid_wr;

  logic         in_fwd_req;
  logic         out_fwd_gnt;
  logic [133:0] in_fwd_data;
  logic         in_fwd_data_wr;
  logic         in_fwd_data_valid;
  logic         in_fwd_data_valid_wr;

  logic [133:0] out_lu_data;
  logic         out_lu_data_wr;
  logic         out_lu_data_valid;
  logic         out_lu_data_valid_wr;

  modport slave (
    input  in_rpt_req, in_rpt_data, in_rpt_data_wr, in_rpt_data_valid, in_rpt_data_valid_wr,
    input  in_fwd_req, in_fwd_data, in_fwd_data_wr, in_fwd_data_valid, in_fwd_data_valid_wr,
    output out_rpt_gnt, out_fwd_gnt,
    output out_lu_data, out_lu_data_wr, out_lu_data_valid, out_lu_data_valid_wr
  );

  modport master (
    output in_rpt_req, in_rpt_data, in_rpt_data_wr, in_rpt_data_valid, in_rpt_data_valid_wr,
    output in_fwd_req, in_fwd_data, in_fwd_data_wr, in_fwd_data_valid, in_fwd_data_valid_wr,
    input  out_rpt_gnt, out_fwd_gnt,
    input  out_lu_data, out_lu_data_wr, out_lu_data_valid, out_lu_data_valid_wr
  );
endinterface

// File: rtl/lupdate_tx_sched.sv
// lupdate_tx_sched: slot-timed, packet-atomic arbiter sharing the lupdate ingress
// between the beacon report (rpt) and forwarded (fwd) sources. Stats: LUPDATE_TX_SCHED_STAT_EN.
module lupdate_tx_sched #(
  parameter int unsigned GUARD_CYCLES   = 16,
  parameter int unsigned MAX_PKT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       in_time_slot_period,
  input  logic              in_beacon_update_master,
  lupdate_tx_sched_if.slave bus,
  output logic              out_slot_start,
  output logic              out_abort
`ifdef LUPDATE_TX_SCHED_STAT_EN
  ,
  output logic [31:0]       out_rpt_pkt_cnt,
  output logic [31:0]       out_fwd_pkt_cnt,
  output logic [15:0]       out_abort_cnt
`endif
);

  typedef enum logic [1:0] {IDLE_S, RPT_S, FWD_S} state_e;

  localparam int unsigned     WD_W    = $clog2(MAX_PKT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_PKT_CYCLES - 1);
  localparam logic [31:0]     GUARD   = 32'(GUARD_CYCLES);

  state_e          state_q, state_d;
  logic [31:0]     slot_cnt_q, slot_cnt_d;
  logic            slot_start_q, slot_start_d;
  logic            tgl_q;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            abort_q, abort_d;
  logic [133:0]    lu_data_q, lu_data_d;
  logic            lu_wr_q, lu_wr_d;
  logic            lu_valid_q, lu_valid_d;
  logic            lu_vwr_q, lu_vwr_d;

  logic            guard;
  logic            toggle_edge;
  logic [133:0]    src_data;
  logic            src_wr, src_valid, src_vwr;

  assign toggle_edge = (in_beacon_update_master != tgl_q);
  assign guard       = (in_time_slot_period > GUARD) &&
                       (slot_cnt_q >= in_time_slot_period - GUARD);

  // Toggle re-alignment wins over the natural wrap; period 0 parks the counter.
  always_comb begin
    slot_cnt_d   = slot_cnt_q + 32'd1;
    slot_start_d = 1'b0;
    if (in_time_slot_period == '0) begin
      slot_cnt_d = '0;
    end else if (toggle_edge || (slot_cnt_q >= in_time_slot_period - 32'd1)) begin
      slot_cnt_d   = '0;
      slot_start_d = 1'b1;
    end
  end

  always_comb begin
    src_data  = bus.in_rpt_data;
    src_wr    = bus.in_rpt_data_wr;
    src_valid = bus.in_rpt_data_valid;
    src_vwr   = bus.in_rpt_data_valid_wr;
    if (state_q == FWD_S) begin
      src_data  = bus.in_fwd_data;
      src_wr    = bus.in_fwd_data_wr;
      src_valid = bus.in_fwd_data_valid;
      src_vwr   = bus.in_fwd_data_valid_wr;
    end
  end

  always_comb begin
    state_d    = state_q;
    wdog_d     = '0;
    abort_d    = 1'b0;
    lu_data_d  = '0;
    lu_wr_d    = 1'b0;
    lu_valid_d = 1'b0;
    lu_vwr_d   = 1'b0;
    unique case (state_q)
      IDLE_S: begin
        if (bus.in_rpt_req)                 state_d = RPT_S;
        else if (bus.in_fwd_req && !guard)  state_d = FWD_S;
      end
      RPT_S, FWD_S: begin
        lu_data_d  = src_data;
        lu_wr_d    = src_wr;
        lu_valid_d = src_valid;
        lu_vwr_d   = src_vwr;
        wdog_d     = wdog_q + WD_W'(1);
        if (src_vwr) begin
          state_d = IDLE_S;
        end else if (wdog_q == WD_LAST) begin
          // Synthetic end-of-packet closes the hung stream downstream.
          lu_data_d  = '0;
          lu_wr_d    = 1'b0;
          lu_valid_d = 1'b0;
          lu_vwr_d   = 1'b1;
          abort_d    = 1'b1;
          state_d    = IDLE_S;
        end
      end
      default: state_d = IDLE_S;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE_S;
      slot_cnt_q   <= '0;
      slot_start_q <= 1'b0;
      tgl_q        <= in_beacon_update_master;
      wdog_q       <= '0;
      abort_q      <= 1'b0;
      lu_data_q    <= '0;
      lu_wr_q      <= 1'b0;
      lu_valid_q   <= 1'b0;
      lu_vwr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      slot_start_q <= slot_start_d;
      tgl_q        <= in_beacon_update_master;
      wdog_q       <= wdog_d;
      abort_q      <= abort_d;
      lu_data_q    <= lu_data_d;
      lu_wr_q      <= lu_wr_d;
      lu_valid_q   <= lu_valid_d;
      lu_vwr_q     <= lu_vwr_d;
    end
  end

  assign bus.out_rpt_gnt          = (state_q == RPT_S);
  assign bus.out_fwd_gnt          = (state_q == FWD_S);
  assign bus.out_lu_data          = lu_data_q;
  assign bus.out_lu_data_wr       = lu_wr_q;
  assign bus.out_lu_data_valid    = lu_valid_q;
  assign bus.out_lu_data_valid_wr = lu_vwr_q;
  assign out_slot_start           = slot_start_q;
  assign out_abort                = abort_q;

`ifdef LUPDATE_TX_SCHED_STAT_EN
  logic [31:0] rpt_cnt_q, fwd_cnt_q;
  logic [15:0] abort_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt_q   <= '0;
      fwd_cnt_q   <= '0;
      abort_cnt_q <= '0;
    end else begin
      if (state_q == RPT_S && src_vwr) rpt_cnt_q   <= rpt_cnt_q + 32'd1;
      if (state_q == FWD_S && src_vwr) fwd_cnt_q   <= fwd_cnt_q + 32'd1;
      if (abort_d)                     abort_cnt_q <= abort_cnt_q + 16'd1;
    end
  end

  assign out_rpt_pkt_cnt = rpt_cnt_q;
  assign out_fwd_pkt_cnt = fwd_cnt_q;
  assign out_abort_cnt   = abort_cnt_q;
`endif

endmodule
